// File: rtl/tdm_timing_ctrl.sv
// TDM frame timing controller: 256-cycle frame counter, bit clock, frame sync and strobes,
// either free-running (master) or locked to an external frame sync (slave) with slip detection.
module tdm_timing_ctrl #(
    parameter int SYNC_OFFSET = 3,
    parameter int SLIP_LIMIT  = 3
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       master,
    input  logic       fs_mode,
    input  logic       ext_fsync,
    output logic [7:0] cnt256_n,
    output logic       bclk,
    output logic       fsync,
    output logic       frame_start,
    output logic       sample_valid,
    output logic       locked
);

    localparam int SW = $clog2(SLIP_LIMIT + 1);
    localparam logic [7:0]    LOAD_CNT  = 8'(SYNC_OFFSET % 256);
    localparam logic [7:0]    ALIGN_CNT = 8'((SYNC_OFFSET + 255) % 256);
    localparam logic [SW-1:0] SLIP_MAX  = SW'(SLIP_LIMIT);

    typedef enum logic [1:0] {StIdle, StAlign, StRun, StDrain} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SW-1:0] slip_q, slip_d;
    logic          frame_seen_q, frame_seen_d;
    logic          master_q, fs_mode_q;
    logic [1:0]    sync_q;
    logic          sync_prev_q;
    logic          edge_q;

    logic          running;
    logic          check_edge;
    logic          aligned;
    logic          slip_hit;
    logic [SW-1:0] slip_inc;

    // Two-flop synchronizer plus registered rising-edge detect
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            sync_prev_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], ext_fsync};
            sync_prev_q <= sync_q[1];
            edge_q      <= sync_q[1] & ~sync_prev_q;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            slip_q       <= '0;
            frame_seen_q <= 1'b0;
            master_q     <= 1'b0;
            fs_mode_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slip_q       <= slip_d;
            frame_seen_q <= frame_seen_d;
            if (state_q == StIdle) begin
                master_q  <= master;
                fs_mode_q <= fs_mode;
            end
        end
    end

    always_comb begin
        running    = (state_q == StRun) || (state_q == StDrain);
        check_edge = running & ~master_q & edge_q;
        aligned    = (cnt_q == ALIGN_CNT);
        slip_inc   = (slip_q == SLIP_MAX) ? slip_q : slip_q + 1'b1;
        slip_hit   = check_edge & ~aligned & (slip_inc == SLIP_MAX);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slip_d       = slip_q;
        frame_seen_d = frame_seen_q;

        if (running) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) frame_seen_d = 1'b1;
        end
        // Misaligned edges only count; the counter is never re-phased while running
        if (check_edge) slip_d = aligned ? '0 : slip_inc;

        unique case (state_q)
            StIdle: begin
                cnt_d        = 8'd0;
                slip_d       = '0;
                frame_seen_d = 1'b0;
                if (enable) state_d = master ? StRun : StAlign;
            end
            StAlign: begin
                cnt_d        = 8'd0;
                slip_d       = '0;
                frame_seen_d = 1'b0;
                if (!enable) begin
                    state_d = StIdle;
                end else if (edge_q) begin
                    cnt_d   = LOAD_CNT;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (slip_hit) begin
                    state_d      = enable ? StAlign : StIdle;
                    cnt_d        = 8'd0;
                    slip_d       = '0;
                    frame_seen_d = 1'b0;
                end else if (!enable) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (slip_hit || (!enable && cnt_q == 8'd255)) begin
                    state_d      = StIdle;
                    cnt_d        = 8'd0;
                    slip_d       = '0;
                    frame_seen_d = 1'b0;
                end else if (enable) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt256_n     = cnt_q;
        bclk         = running & cnt_q[1];
        fsync        = running & (fs_mode_q ? ~cnt_q[7] : (&cnt_q[7:2]));
        frame_start  = running & (cnt_q == 8'd0);
        sample_valid = running & (cnt_q == 8'd1) & frame_seen_q;
        locked       = running;
    end

endmodule

// File: tb/tb_tdm_timing_ctrl.sv
// Directed self-checking bench for tdm_timing_ctrl: master pulse/duty modes, drain,
// slave lock, slip/relock, align abort and asynchronous reset.
module tb_tdm_timing_ctrl;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       master;
    logic       fs_mode;
    logic       ext_fsync;
    logic [7:0] cnt256_n;
    logic       bclk, fsync, frame_start, sample_valid, locked;

    int n_cmp = 0;
    int n_bad = 0;
    int edges[7];
    int n_edges;

    logic [12:0] obs;
    logic [12:0] exp_v;

    tdm_timing_ctrl #(
        .SYNC_OFFSET(3),
        .SLIP_LIMIT (3)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .master      (master),
        .fs_mode     (fs_mode),
        .ext_fsync   (ext_fsync),
        .cnt256_n    (cnt256_n),
        .bclk        (bclk),
        .fsync       (fsync),
        .frame_start (frame_start),
        .sample_valid(sample_valid),
        .locked      (locked)
    );

    always #2 mclk = ~mclk;

    assign obs = {cnt256_n, bclk, fsync, frame_start, sample_valid, locked};

    // Expected running outputs for an absolute counter value c_abs
    function automatic logic [12:0] exp_run(input int c_abs, input bit fsm, input bit sv_ok);
        logic [7:0] c;
        logic       fs;
        c  = 8'(c_abs % 256);
        fs = fsm ? (c < 8'd128) : (c >= 8'd252);
        return {c, c[1], fs, (c == 8'd0), ((c == 8'd1) && sv_ok), 1'b1};
    endfunction

    function automatic bit ext_level(input int t);
        for (int i = 0; i < n_edges; i++)
            if (t >= edges[i] && t < edges[i] + 16) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        ext_fsync = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        master    = 1'b1;
        fs_mode   = 1'b0;
        ext_fsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, 13'd0);
            end
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL idle_after_reset i=%0d got=%h exp=%h", i, obs, 13'd0);
            end
        end
    endtask

    task automatic test_master(input bit fsm, input int n);
        do_reset();
        master  = 1'b1;
        fs_mode = fsm;
        enable  = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            exp_v = exp_run(k, fsm, k >= 256);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL master_fsm%0d k=%0d got=%h exp=%h", fsm, k, obs, exp_v);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        master  = 1'b1;
        fs_mode = 1'b0;
        enable  = 1'b1;
        for (int k = 0; k <= 260; k++) begin
            tick();
            exp_v = (k <= 255) ? exp_run(k, 1'b0, 1'b0) : 13'd0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL drain_to_idle k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k == 100) enable = 1'b0;
        end
        enable = 1'b1;
        for (int k = 0; k < 600; k++) begin
            tick();
            exp_v = exp_run(k, 1'b0, k >= 256);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL drain_resume k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k == 100) enable = 1'b0;
            if (k == 200) enable = 1'b1;
        end
    endtask

    task automatic test_align_abort();
        do_reset();
        master = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL align_hold i=%0d got=%h exp=%h", i, obs, 13'd0);
            end
        end
        enable = 1'b0;
        tick();
        master = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = exp_run(k, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL align_abort k=%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    // mode 0: plain lock; 1: three shifted edges lose lock then relock; 2: isolated slips
    task automatic test_slave(input int mode);
        int n, unlock_t, relock_t;
        do_reset();
        master  = 1'b0;
        fs_mode = 1'b0;
        enable  = 1'b1;
        unlock_t = 1 << 30;
        relock_t = 1 << 30;
        if (mode == 0) begin
            edges = '{0, 256, 512, 0, 0, 0, 0};
            n_edges = 3;
            n = 800;
        end else if (mode == 1) begin
            edges = '{0, 256, 512, 808, 1064, 1320, 1576};
            n_edges = 7;
            n = 1700;
            unlock_t = 1324;
            relock_t = 1580;
        end else begin
            edges = '{0, 256, 552, 768, 1064, 1320, 0};
            n_edges = 6;
            n = 1500;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL slave_align_wait m=%0d i=%0d got=%h exp=%h", mode, i, obs, 13'd0);
            end
        end
        for (int t = 0; t < n; t++) begin
            if (t < 4)             exp_v = 13'd0;
            else if (t < unlock_t) exp_v = exp_run(t - 1, 1'b0, t > 258);
            else if (t < relock_t) exp_v = 13'd0;
            else                   exp_v = exp_run(t - relock_t + 3, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL slave m=%0d t=%0d got=%h exp=%h", mode, t, obs, exp_v);
            end
            ext_fsync = ext_level(t);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        master  = 1'b1;
        fs_mode = 1'b0;
        enable  = 1'b1;
        for (int k = 0; k <= 130; k++) tick();
        exp_v = exp_run(130, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL pre_reset_cnt got=%h exp=%h", obs, exp_v);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, 13'd0);
        end
        tick();
        n_cmp++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_held got=%h exp=%h", obs, 13'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_v = exp_run(k, 1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL restart k=%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        master    = 1'b0;
        fs_mode   = 1'b0;
        ext_fsync = 1'b0;
        n_edges   = 0;
        test_reset();
        test_master(1'b0, 600);
        test_master(1'b1, 300);
        test_drain();
        test_align_abort();
        test_slave(0);
        test_slave(1);
        test_slave(2);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_timing_ctrl.md
TDM_TIMING_CTRL -- requirements
Module: tdm_timing_ctrl

Interface
REQ-001 SHALL provide parameter SYNC_OFFSET, default 3, giving the cnt256_n value loaded on a detected external frame-sync edge in slave mode.
REQ-002 SHALL provide parameter SLIP_LIMIT, default 3, giving the number of consecutive misaligned external sync edges that causes loss of lock.
REQ-003 SHALL have port mclk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: request to run frame timing.
REQ-006 SHALL have port master, input, 1 bit: 1 = generate timing internally; 0 = slave to ext_fsync; sampled only in IDLE.
REQ-007 SHALL have port fs_mode, input, 1 bit: 0 = one-bit-slot fsync pulse; 1 = 50 % duty fsync; sampled only in IDLE.
REQ-008 SHALL have port ext_fsync, input, 1 bit: asynchronous external frame sync.
REQ-009 SHALL have port cnt256_n, output, 8 bits: frame phase counter feeding the TDM input/output datapaths.
REQ-010 SHALL have port bclk, output, 1 bit: bit clock, mclk/4.
REQ-011 SHALL have port fsync, output, 1 bit: frame sync.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle frame boundary strobe.
REQ-013 SHALL have port sample_valid, output, 1 bit: one-cycle strobe marking the cycle in which datapath channel outputs are fresh.
REQ-014 SHALL have port locked, output, 1 bit: timing is running and aligned.

Function
REQ-015 SHALL implement the states IDLE, ALIGN, RUN and DRAIN.
REQ-016 IDLE SHALL hold cnt256_n=0, bclk=0, fsync=0, locked=0 and all strobes=0.
REQ-017 IDLE with enable=1 and master=1 SHALL go to RUN; the first RUN cycle has cnt256_n=0.
REQ-018 IDLE with enable=1 and master=0 SHALL go to ALIGN.
REQ-019 ALIGN SHALL hold cnt256_n=0 until a synchronized ext_fsync rising edge, then load cnt256_n=SYNC_OFFSET and enter RUN.
REQ-020 ALIGN with enable=0 SHALL return to IDLE.
REQ-021 ext_fsync SHALL pass a 2-flop synchronizer, followed by a registered rising-edge detect.
REQ-022 In RUN and DRAIN, cnt256_n SHALL increment by 1 each mclk, wrapping 255->0.
REQ-023 In RUN and DRAIN, bclk SHALL equal cnt256_n[1], so bclk rises where cnt256_n[1:0] changes 1->2.
REQ-024 fs_mode=0 SHALL make fsync=1 exactly while cnt256_n[7:2]==63.
REQ-025 fs_mode=1 SHALL make fsync=1 while cnt256_n[7]==0.
REQ-026 frame_start SHALL be 1 in any RUN/DRAIN cycle with cnt256_n==0.
REQ-027 sample_valid SHALL be 1 in RUN/DRAIN cycles with cnt256_n==1, only once at least one complete 256-cycle frame has elapsed since entering RUN.
REQ-028 The first cnt256_n==1 cycle after RUN entry SHALL be suppressed for sample_valid.
REQ-029 locked SHALL be 1 in RUN and DRAIN and 0 in all other states.
REQ-030 In slave RUN, a detected edge with cnt256_n==SYNC_OFFSET-1 (mod 256) SHALL be counted as aligned and clear the slip counter.
REQ-031 In slave RUN, any other detected edge SHALL increment the saturating slip counter without changing cnt256_n.
REQ-032 A slip counter reaching SLIP_LIMIT SHALL force ALIGN, cnt256_n=0 and locked=0.
REQ-033 A missing ext_fsync SHALL NOT by itself cause a slip.
REQ-034 enable=0 in RUN SHALL enter DRAIN.
REQ-035 DRAIN SHALL continue counting and go to IDLE on the cycle after cnt256_n==255.
REQ-036 enable=1 during DRAIN SHALL return to RUN with no counter disturbance.
REQ-037 A slip limit reached in DRAIN SHALL go to IDLE.
REQ-038 An aligned edge and a slip increment can never coincide; when an edge arrives in the same cycle as cnt256_n wraps, the edge check SHALL take priority over frame_start handling (both may assert).

Reset
REQ-039 rst_n=0 SHALL asynchronously force IDLE, cnt256_n=0, bclk=0, fsync=0, frame_start=0, sample_valid=0, locked=0, slip counter=0, synchronizer flops=0 and the frame-elapsed flag=0.
REQ-040 Reset asserted mid-frame SHALL take effect immediately; after release, operation SHALL restart from IDLE.

Verification
REQ-041 Master, fs_mode=0, enable=1 held: cnt256_n 0..255 repeating; bclk period 4 mclk; fsync high for cnt 252..255; frame_start at cnt=0; sample_valid first at the second cnt=1 after start.
REQ-042 Master, fs_mode=1: fsync high for cnt 0..127 and low for 128..255.
REQ-043 Master, enable dropped at cnt=100: counting continues to 255, then IDLE with outputs 0; enable re-asserted at cnt=200 during DRAIN gives seamless RUN.
REQ-044 Slave, ext_fsync rising every 1024 ns (mclk 4 ns): lock achieved with cnt256_n=SYNC_OFFSET at edge-detect; subsequent edges land at cnt=2; locked stays 1.
REQ-045 Slave, locked, ext_fsync shifted by 40 mclk for 3 frames: slip count 1,2,3, then ALIGN, locked=0, relock on the next edge; a single shifted edge followed by an aligned edge keeps lock.
REQ-046 rst_n pulsed low at cnt=130 in RUN: all outputs 0 asynchronously; after release with enable=1 and master=1, cnt restarts at 0.
